// File: rtl/axi_mem_arbiter_if.sv
// Cache-side request/response signals and the AXI4 master channels of the I/D refill arbiter.
// master = arbiter side; slave = caches plus AXI slave environment.
interface axi_mem_arbiter_if;
  logic        i_rd_req;
  logic [31:0] i_rd_addr;
  logic [63:0] i_rd_data;
  logic        i_rd_valid;
  logic        i_rd_done;
  logic        d_rd_req;
  logic [31:0] d_rd_addr;
  logic        d_single;
  logic [63:0] d_rd_data;
  logic        d_rd_valid;
  logic        d_rd_done;
  logic        d_wr_req;
  logic [31:0] d_wr_addr;
  logic [63:0] d_wr_data;
  logic [7:0]  d_wr_strb;
  logic [3:0]  d_wr_beat;
  logic        d_wr_ready;
  logic        d_wr_done;
  logic        bus_err;

  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid;
  logic        awready;
  logic [63:0] wdata;
  logic [7:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [63:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  modport master (
    input  i_rd_req, i_rd_addr, d_rd_req, d_rd_addr, d_single,
           d_wr_req, d_wr_addr, d_wr_data, d_wr_strb,
           awready, wready, bid, bresp, bvalid,
           arready, rid, rdata, rresp, rlast, rvalid,
    output i_rd_data, i_rd_valid, i_rd_done, d_rd_data, d_rd_valid, d_rd_done,
           d_wr_beat, d_wr_ready, d_wr_done, bus_err,
           awid, awaddr, awlen, awsize, awburst, awvalid,
           wdata, wstrb, wlast, wvalid, bready,
           arid, araddr, arlen, arsize, arburst, arvalid, rready
  );

  modport slave (
    output i_rd_req, i_rd_addr, d_rd_req, d_rd_addr, d_single,
           d_wr_req, d_wr_addr, d_wr_data, d_wr_strb,
           awready, wready, bid, bresp, bvalid,
           arready, rid, rdata, rresp, rlast, rvalid,
    input  i_rd_data, i_rd_valid, i_rd_done, d_rd_data, d_rd_valid, d_rd_done,
           d_wr_beat, d_wr_ready, d_wr_done, bus_err,
           awid, awaddr, awlen, awsize, awburst, awvalid,
           wdata, wstrb, wlast, wvalid, bready,
           arid, araddr, arlen, arsize, arburst, arvalid, rready
  );
endinterface

// File: rtl/axi_mem_arbiter.sv
// Serialises I-cache refills and D-cache refill/write-back onto one AXI4 master port,
// one burst at a time, round-robin between I and D, write-back ahead of D refill.
module axi_mem_arbiter #(
  parameter int unsigned BEATS = 8,
  parameter logic [3:0]  I_ID  = 4'd0,
  parameter logic [3:0]  D_ID  = 4'd1
) (
  input logic               clk,
  input logic               rst,
  axi_mem_arbiter_if.master bus
);
  localparam logic [3:0] FULL_LEN = 4'(BEATS - 1);

  typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_AW, S_W, S_B} state_e;

  state_e      state_q, state_d;
  logic        rr_q, rr_d;
  logic        own_d_q, own_d_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  id_q, id_d;
  logic [3:0]  len_q, len_d;
  logic [3:0]  beat_q, beat_d;
  logic        err_q, err_d;

  logic d_want, serve_d, serve_i;
  logic r_hs, r_end, w_hs, w_last, b_hs;
  logic unused_ids;

  assign unused_ids = ^{bus.bid, bus.rid};

  // rr_q=0 favours D on contention; it is pointed away from whichever side is served
  assign d_want  = bus.d_wr_req | bus.d_rd_req;
  assign serve_d = d_want & (~bus.i_rd_req | ~rr_q);
  assign serve_i = bus.i_rd_req & (~d_want | rr_q);

  assign r_hs   = (state_q == S_R) & bus.rvalid;
  assign r_end  = r_hs & bus.rlast;
  assign w_hs   = (state_q == S_W) & bus.wready;
  assign w_last = (beat_q == len_q);
  assign b_hs   = (state_q == S_B) & bus.bvalid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      rr_q    <= 1'b0;
      own_d_q <= 1'b0;
      addr_q  <= '0;
      id_q    <= '0;
      len_q   <= '0;
      beat_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      own_d_q <= own_d_d;
      addr_q  <= addr_d;
      id_q    <= id_d;
      len_q   <= len_d;
      beat_q  <= beat_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    own_d_d = own_d_q;
    addr_d  = addr_q;
    id_d    = id_q;
    len_d   = len_q;
    beat_d  = beat_q;
    err_d   = err_q | (r_hs & (bus.rresp != 2'b00)) | (b_hs & (bus.bresp != 2'b00));
    unique case (state_q)
      S_IDLE: begin
        if (serve_d) begin
          own_d_d = 1'b1;
          id_d    = D_ID;
          rr_d    = 1'b1;
          len_d   = bus.d_single ? 4'd0 : FULL_LEN;
          if (bus.d_wr_req) begin
            addr_d  = bus.d_wr_addr;
            state_d = S_AW;
          end else begin
            addr_d  = bus.d_rd_addr;
            state_d = S_AR;
          end
        end else if (serve_i) begin
          own_d_d = 1'b0;
          id_d    = I_ID;
          rr_d    = 1'b0;
          len_d   = FULL_LEN;
          addr_d  = bus.i_rd_addr;
          state_d = S_AR;
        end
      end
      S_AR: if (bus.arready) state_d = S_R;
      S_R:  if (r_end) state_d = S_IDLE;
      S_AW: if (bus.awready) state_d = S_W;
      S_W: begin
        if (w_hs) begin
          if (w_last) begin
            beat_d  = '0;
            state_d = S_B;
          end else begin
            beat_d = beat_q + 4'd1;
          end
        end
      end
      S_B:  if (b_hs) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.arvalid = (state_q == S_AR);
  assign bus.araddr  = addr_q;
  assign bus.arid    = id_q;
  assign bus.arlen   = {4'b0000, len_q};
  assign bus.arsize  = 3'd3;
  assign bus.arburst = 2'b01;
  assign bus.rready  = (state_q == S_R);

  assign bus.awvalid = (state_q == S_AW);
  assign bus.awaddr  = addr_q;
  assign bus.awid    = id_q;
  assign bus.awlen   = {4'b0000, len_q};
  assign bus.awsize  = 3'd3;
  assign bus.awburst = 2'b01;

  assign bus.wvalid  = (state_q == S_W);
  assign bus.wdata   = bus.d_wr_data;
  assign bus.wstrb   = bus.d_wr_strb;
  assign bus.wlast   = (state_q == S_W) & w_last;
  assign bus.bready  = (state_q == S_B);

  assign bus.i_rd_data  = bus.rdata;
  assign bus.i_rd_valid = r_hs & ~own_d_q;
  assign bus.i_rd_done  = r_end & ~own_d_q;
  assign bus.d_rd_data  = bus.rdata;
  assign bus.d_rd_valid = r_hs & own_d_q;
  assign bus.d_rd_done  = r_end & own_d_q;
  assign bus.d_wr_beat  = beat_q;
  assign bus.d_wr_ready = w_hs;
  assign bus.d_wr_done  = b_hs;
  assign bus.bus_err    = err_q;
endmodule

// File: tb/tb_axi_mem_arbiter.sv
// Scoreboard bench for axi_mem_arbiter: an AXI slave model answers bursts, expected
// address phases and beats are queued at stimulus time and compared as the DUT emits them.
module tb_axi_mem_arbiter;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  axi_mem_arbiter_if bus();

  axi_mem_arbiter #(.BEATS(8), .I_ID(4'd0), .D_ID(4'd1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {logic [3:0] id; logic [31:0] addr; logic [7:0] len;} ax_t;
  typedef struct packed {logic last; logic [3:0] beat; logic [63:0] data;} bt_t;

  ax_t ar_q[$];
  ax_t aw_q[$];
  bt_t w_q[$];
  bt_t i_q[$];
  bt_t d_q[$];

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int unsigned ar_stall_seen = 0;
  int unsigned wlast_hs = 0;

  int unsigned ar_stall  = 0;
  bit          w_alt     = 1'b0;
  logic [1:0]  rresp_cfg = 2'b00;

  function automatic logic [63:0] rfn(input logic [31:0] a, input int unsigned b);
    return {a ^ 32'hC0DE_0000, 32'(b) ^ 32'h1111_0000};
  endfunction

  function automatic logic [63:0] wfn(input logic [31:0] a, input logic [3:0] b);
    return {32'hD00D_0000 | 32'(b), ~a};
  endfunction

  assign bus.d_wr_data = wfn(bus.d_wr_addr, bus.d_wr_beat);
  assign bus.d_wr_strb = 8'hF0 ^ {4'h0, bus.d_wr_beat};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // AXI slave: samples handshakes at negedge, updates its outputs just after posedge
  initial begin : slave
    bit          ar_hs, r_hs, w_hs, w_lst, b_hs, s_rd, s_b, w_tog;
    logic [31:0] a, s_addr;
    logic [7:0]  l, s_len, s_beat;
    int unsigned ar_cnt;
    s_rd = 0; s_b = 0; w_tog = 0; ar_cnt = 0; s_addr = '0; s_len = '0; s_beat = '0;
    bus.arready = 1'b1; bus.awready = 1'b1; bus.wready = 1'b1;
    bus.rvalid = 1'b0; bus.rdata = '0; bus.rlast = 1'b0; bus.rresp = 2'b00; bus.rid = 4'd0;
    bus.bvalid = 1'b0; bus.bresp = 2'b00; bus.bid = 4'd1;
    forever begin
      @(negedge clk);
      ar_hs = bus.arvalid && bus.arready;
      a     = bus.araddr;
      l     = bus.arlen;
      r_hs  = bus.rvalid && bus.rready;
      w_hs  = bus.wvalid && bus.wready;
      w_lst = bus.wlast;
      b_hs  = bus.bvalid && bus.bready;
      if (bus.arvalid && !bus.arready) ar_cnt++;
      @(posedge clk); #2;
      if (rst) begin
        s_rd = 0; s_b = 0; ar_cnt = 0; w_tog = 0;
      end else begin
        if (ar_hs) begin
          s_rd = 1; s_addr = a; s_len = l; s_beat = '0; ar_cnt = 0;
        end else if (r_hs) begin
          if (s_beat == s_len) s_rd = 0;
          else s_beat++;
        end
        if (w_hs && w_lst) s_b = 1;
        if (b_hs) s_b = 0;
        w_tog = !w_tog;
      end
      bus.arready = (ar_cnt >= ar_stall);
      bus.wready  = w_alt ? w_tog : 1'b1;
      bus.rvalid  = s_rd;
      bus.rdata   = rfn(s_addr, s_beat);
      bus.rlast   = s_rd && (s_beat == s_len);
      bus.rresp   = rresp_cfg;
      bus.bvalid  = s_b;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.arvalid) begin
        if (ar_q.size() == 0) check("ar_unexpected", 1, 0);
        else begin
          check("araddr", bus.araddr, ar_q[0].addr);
          check("arid", bus.arid, ar_q[0].id);
          check("arlen", bus.arlen, ar_q[0].len);
          check("ar_size_burst", {bus.arsize, bus.arburst}, {3'd3, 2'b01});
          if (bus.arready) void'(ar_q.pop_front());
          else ar_stall_seen++;
        end
      end
      if (bus.awvalid) begin
        if (aw_q.size() == 0) check("aw_unexpected", 1, 0);
        else begin
          check("awaddr", bus.awaddr, aw_q[0].addr);
          check("awid", bus.awid, aw_q[0].id);
          check("awlen", bus.awlen, aw_q[0].len);
          check("aw_size_burst", {bus.awsize, bus.awburst}, {3'd3, 2'b01});
          if (bus.awready) void'(aw_q.pop_front());
        end
      end
      if (bus.wvalid) begin
        check("w_before_aw", aw_q.size(), 0);
        if (w_q.size() == 0) check("w_unexpected", 1, 0);
        else begin
          check("d_wr_beat", bus.d_wr_beat, w_q[0].beat);
          check("wdata", bus.wdata, w_q[0].data);
          check("wstrb", bus.wstrb, 8'hF0 ^ {4'h0, w_q[0].beat});
          check("wlast", bus.wlast, w_q[0].last);
          check("d_wr_ready", bus.d_wr_ready, bus.wready);
          if (bus.wready) begin
            if (bus.wlast) wlast_hs++;
            void'(w_q.pop_front());
          end
        end
      end
      if (bus.i_rd_valid || bus.i_rd_done) begin
        check("i_d_exclusive", bus.d_rd_valid, 0);
        if (i_q.size() == 0) check("i_unexpected", 1, 0);
        else begin
          check("i_rd_valid", bus.i_rd_valid, 1);
          check("i_rd_data", bus.i_rd_data, i_q[0].data);
          check("i_rd_done", bus.i_rd_done, i_q[0].last);
          void'(i_q.pop_front());
        end
      end
      if (bus.d_rd_valid || bus.d_rd_done) begin
        if (d_q.size() == 0) check("d_unexpected", 1, 0);
        else begin
          check("d_rd_valid", bus.d_rd_valid, 1);
          check("d_rd_data", bus.d_rd_data, d_q[0].data);
          check("d_rd_done", bus.d_rd_done, d_q[0].last);
          void'(d_q.pop_front());
        end
      end
    end
  end

  task automatic exp_read(input bit d_side, input logic [3:0] id, input logic [31:0] a,
                          input int unsigned nb);
    bt_t e;
    ar_q.push_back('{id: id, addr: a, len: 8'(nb - 1)});
    for (int unsigned k = 0; k < nb; k++) begin
      e = '{last: (k == nb - 1), beat: 4'(k), data: rfn(a, k)};
      if (d_side) d_q.push_back(e);
      else i_q.push_back(e);
    end
  endtask

  task automatic exp_write(input logic [31:0] a, input int unsigned nb);
    aw_q.push_back('{id: 4'd1, addr: a, len: 8'(nb - 1)});
    for (int unsigned k = 0; k < nb; k++)
      w_q.push_back('{last: (k == nb - 1), beat: 4'(k), data: wfn(a, 4'(k))});
  endtask

  // which: 0 = I read, 1 = D read, 2 = D write-back; held until the matching done pulse
  task automatic req(input int which, input logic [31:0] a, input bit single);
    bit seen = 1'b0;
    case (which)
      0: begin bus.i_rd_addr = a; bus.i_rd_req = 1'b1; end
      1: begin bus.d_rd_addr = a; bus.d_single = single; bus.d_rd_req = 1'b1; end
      default: begin bus.d_wr_addr = a; bus.d_wr_req = 1'b1; end
    endcase
    for (int n = 0; n < 400 && !seen; n++) begin
      @(negedge clk);
      seen = (which == 0) ? bus.i_rd_done : (which == 1) ? bus.d_rd_done : bus.d_wr_done;
    end
    if (!seen) check($sformatf("req%0d_done_timeout", which), 0, 1);
    @(posedge clk); #1;
    case (which)
      0: bus.i_rd_req = 1'b0;
      1: begin bus.d_rd_req = 1'b0; bus.d_single = 1'b0; end
      default: bus.d_wr_req = 1'b0;
    endcase
  endtask

  task automatic flush();
    ar_q.delete(); aw_q.delete(); w_q.delete(); i_q.delete(); d_q.delete();
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    bus.i_rd_req = 1'b0; bus.d_rd_req = 1'b0; bus.d_wr_req = 1'b0; bus.d_single = 1'b0;
    flush();
    @(negedge clk);
    check("rst_outputs", {bus.arvalid, bus.awvalid, bus.wvalid, bus.wlast, bus.rready, bus.bready,
                          bus.i_rd_valid, bus.i_rd_done, bus.d_rd_valid, bus.d_rd_done,
                          bus.d_wr_ready, bus.d_wr_done, bus.d_wr_beat}, 0);
    check("rst_bus_err", bus.bus_err, 0);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic drain(input string tag);
    int left = 1;
    for (int n = 0; n < 300 && left != 0; n++) begin
      @(negedge clk);
      left = ar_q.size() + aw_q.size() + w_q.size() + i_q.size() + d_q.size();
    end
    check({"drain_", tag}, 64'(left), 0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int unsigned base, beats;
    rst = 1'b1;
    bus.i_rd_req = 1'b0; bus.i_rd_addr = '0;
    bus.d_rd_req = 1'b0; bus.d_rd_addr = '0; bus.d_single = 1'b0;
    bus.d_wr_req = 1'b0; bus.d_wr_addr = '0;
    repeat (3) @(posedge clk);

    // 1: single I refill, ARVALID one cycle after request
    do_reset();
    exp_read(1'b0, 4'd0, 32'h8000_0000, 8);
    fork
      req(0, 32'h8000_0000, 1'b0);
      begin
        @(negedge clk); check("t1_arvalid_req_cycle", bus.arvalid, 0);
        @(negedge clk); check("t1_arvalid_next_cycle", bus.arvalid, 1);
      end
    join
    drain("t1");

    // 2: simultaneous I/D after reset -> D first, then I; twice
    do_reset();
    exp_read(1'b1, 4'd1, 32'h8000_0100, 8);
    exp_read(1'b0, 4'd0, 32'h8000_0200, 8);
    fork
      req(1, 32'h8000_0100, 1'b0);
      req(0, 32'h8000_0200, 1'b0);
    join
    exp_read(1'b1, 4'd1, 32'h8000_0300, 8);
    exp_read(1'b0, 4'd0, 32'h8000_0400, 8);
    fork
      req(1, 32'h8000_0300, 1'b0);
      req(0, 32'h8000_0400, 1'b0);
    join
    drain("t2");

    // 3: write-back precedes D refill at the same line
    do_reset();
    base = wlast_hs;
    exp_write(32'h8000_1000, 8);
    exp_read(1'b1, 4'd1, 32'h8000_1000, 8);
    fork
      req(2, 32'h8000_1000, 1'b0);
      req(1, 32'h8000_1000, 1'b0);
    join
    drain("t3");
    check("t3_wlast_once", wlast_hs - base, 1);

    // 4: ARREADY stalled 5 cycles, WREADY alternating
    do_reset();
    ar_stall = 5;
    w_alt = 1'b1;
    base = wlast_hs;
    beats = ar_stall_seen;
    exp_write(32'h8000_3000, 8);
    exp_read(1'b0, 4'd0, 32'h8000_2000, 8);
    fork
      req(0, 32'h8000_2000, 1'b0);
      req(2, 32'h8000_3000, 1'b0);
    join
    drain("t4");
    check("t4_wlast_once", wlast_hs - base, 1);
    check("t4_ar_stall_cycles", ar_stall_seen - beats, 5);
    ar_stall = 0;
    w_alt = 1'b0;

    // 5: reset after the third beat abandons the burst
    do_reset();
    exp_read(1'b0, 4'd0, 32'h8000_4000, 8);
    bus.i_rd_addr = 32'h8000_4000;
    bus.i_rd_req = 1'b1;
    beats = 0;
    for (int n = 0; n < 100 && beats < 3; n++) begin
      @(negedge clk);
      if (bus.i_rd_valid) beats++;
    end
    check("t5_three_beats", beats, 3);
    @(posedge clk); #1;
    rst = 1'b1;
    bus.i_rd_req = 1'b0;
    flush();
    @(negedge clk);
    check("t5_rst_outputs", {bus.arvalid, bus.rready, bus.i_rd_valid, bus.i_rd_done,
                             bus.d_rd_valid, bus.awvalid, bus.wvalid, bus.bready}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      check("t5_no_done", {bus.i_rd_done, bus.arvalid}, 0);
    end
    @(posedge clk); #1;
    exp_read(1'b0, 4'd0, 32'h8000_5000, 8);
    fork
      req(0, 32'h8000_5000, 1'b0);
      begin
        @(negedge clk); check("t5_arvalid_req_cycle", bus.arvalid, 0);
        @(negedge clk); check("t5_arvalid_next_cycle", bus.arvalid, 1);
      end
    join
    drain("t5");

    // 6: single-beat D read with SLVERR -> sticky bus_err
    do_reset();
    rresp_cfg = 2'b10;
    exp_read(1'b1, 4'd1, 32'h1000_0040, 1);
    req(1, 32'h1000_0040, 1'b1);
    drain("t6");
    @(negedge clk);
    check("t6_bus_err_set", bus.bus_err, 1);
    rresp_cfg = 2'b00;
    exp_read(1'b1, 4'd1, 32'h1000_0048, 1);
    req(1, 32'h1000_0048, 1'b1);
    drain("t6b");
    repeat (5) @(negedge clk);
    check("t6_bus_err_sticky", bus.bus_err, 1);
    do_reset();
    @(negedge clk);
    check("t6_bus_err_cleared", bus.bus_err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
